// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU / multiply-divide unit:
// base ALU function codes, RV-M funct3 codes and the control FSM states.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_PASSB = 4'b0011;
  localparam logic [3:0] ALU_OR    = 4'b0100;
  localparam logic [3:0] ALU_AND   = 4'b0101;
  localparam logic [3:0] ALU_XOR   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_SLT   = 4'b1101;
  localparam logic [3:0] ALU_SLTU  = 4'b1111;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic cf;
    logic zf;
    logic vf;
    logic sf;
  } flags_t;

endpackage

// File: rtl/mdu_iter.sv
// Iterative RV-M datapath: XLEN shift-add / restoring-divide steps over
// magnitudes, then one sign-fixup cycle in which done is raised.
// Divide steps exist only when ALU_DIV_EN is defined.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);

  logic [2*XLEN-1:0] acc, acc_nxt;
  logic [XLEN-1:0]   mb;
  logic [SHW-1:0]    cnt;
  logic              run, fix, neg_q;
  logic [2:0]        fn_q;
  logic              a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0]   ma, mbv;
  logic [XLEN:0]     msum;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res;

  // Signed operands: MUL/MULH/MULHSU take a signed, MUL/MULH take b signed;
  // DIV/REM (funct[0]=0) take both signed.
  always_comb begin
    a_sgn = funct[2] ? ~funct[0] : (funct != MD_MULHU);
    b_sgn = funct[2] ? ~funct[0] : ~funct[1];
    sa    = a_sgn & a[XLEN-1];
    sb    = b_sgn & b[XLEN-1];
    ma    = sa ? (~a + 1'b1) : a;
    mbv   = sb ? (~b + 1'b1) : b;
  end

`ifdef ALU_DIV_EN
  logic          sa_q;
  logic [XLEN:0] dsub;
  logic [XLEN-1:0] q, rm, div_res;
`endif

  always_comb begin
    acc_nxt = acc;
    msum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mb : {XLEN{1'b0}})};
`ifdef ALU_DIV_EN
    // Restoring step: trial-subtract the divisor from {rem, next dividend bit}.
    dsub = acc[2*XLEN-1:XLEN-1] - {1'b0, mb};
    if (fn_q[2]) begin
      if (!dsub[XLEN]) acc_nxt = {dsub[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else             acc_nxt = {acc[2*XLEN-2:0], 1'b0};
    end else
`endif
      acc_nxt = {msum, acc[XLEN-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      mb    <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      fix   <= 1'b0;
      neg_q <= 1'b0;
      fn_q  <= '0;
`ifdef ALU_DIV_EN
      sa_q  <= 1'b0;
`endif
    end else begin
      fix <= 1'b0;
      if (start) begin
        acc   <= {{XLEN{1'b0}}, ma};
        mb    <= mbv;
        cnt   <= '0;
        run   <= 1'b1;
        neg_q <= sa ^ sb;
        fn_q  <= funct;
`ifdef ALU_DIV_EN
        sa_q  <= sa;
`endif
      end else if (run) begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
        if (cnt == '1) begin
          run <= 1'b0;
          fix <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    prod    = neg_q ? (~acc + 1'b1) : acc;
    mul_res = (fn_q == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef ALU_DIV_EN
    q       = acc[XLEN-1:0];
    rm      = acc[2*XLEN-1:XLEN];
    div_res = fn_q[1] ? (sa_q ? (~rm + 1'b1) : rm) : (neg_q ? (~q + 1'b1) : q);
    res     = fn_q[2] ? div_res : mul_res;
`else
    res     = mul_res;
`endif
    done    = fix;
  end

endmodule

// File: rtl/alu_seq_mdu.sv
// Execute-stage ALU: single-cycle RV32I functions plus an iterative RV-M
// unit behind valid/ready handshakes. Define ALU_DIV_EN to build the divider.
module alu_seq_mdu
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alufn,
  input  logic            md_sel,
  input  logic [2:0]      md_funct,
  input  logic            itype,
  input  logic [SHW-1:0]  shamt,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] r,
  output logic            cf,
  output logic            zf,
  output logic            vf,
  output logic            sf,
  output logic            busy
);

  state_t          state, state_nxt;
  flags_t          flg_q, alu_f;
  logic [XLEN-1:0] bop, sum, alu_r, md_val, mdu_res;
  logic            sub, carry, md_spec, accept, mdu_start, mdu_done;
  logic [SHW-1:0]  sh;

  function automatic flags_t md_flags(input logic [XLEN-1:0] v);
    md_flags = '{cf: 1'b0, zf: (v == '0), vf: 1'b0, sf: v[XLEN-1]};
  endfunction

  // Flags always come from the adder, which subtracts whenever alufn[0] is set.
  always_comb begin
    sub          = alufn[0];
    bop          = sub ? ~b : b;
    {carry, sum} = {1'b0, a} + {1'b0, bop} + {{XLEN{1'b0}}, sub};
    sh           = itype ? shamt : b[SHW-1:0];
    alu_f.cf     = carry;
    alu_f.zf     = (sum == '0);
    alu_f.sf     = sum[XLEN-1];
    alu_f.vf     = a[XLEN-1] ^ ~b[XLEN-1] ^ sum[XLEN-1] ^ carry;
    alu_r        = '0;
    case (alufn)
      ALU_ADD, ALU_SUB: alu_r = sum;
      ALU_PASSB:        alu_r = b;
      ALU_OR:           alu_r = a | b;
      ALU_AND:          alu_r = a & b;
      ALU_XOR:          alu_r = a ^ b;
      ALU_SRL:          alu_r = a >> sh;
      ALU_SLL:          alu_r = a << sh;
      ALU_SRA:          alu_r = $signed(a) >>> sh;
      ALU_SLT:          alu_r = {{(XLEN-1){1'b0}}, alu_f.sf ^ alu_f.vf};
      ALU_SLTU:         alu_r = {{(XLEN-1){1'b0}}, ~carry};
      default:          alu_r = '0;
    endcase
  end

  // M-ops resolved at accept without iterating.
  always_comb begin
    md_spec = 1'b0;
    md_val  = '0;
`ifdef ALU_DIV_EN
    if (md_funct[2]) begin
      if (b == '0) begin
        md_spec = 1'b1;
        md_val  = md_funct[1] ? a : '1;
      end else if (!md_funct[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1) begin
        md_spec = 1'b1;
        md_val  = md_funct[1] ? '0 : a;
      end
    end
`else
    md_spec = md_funct[2];
`endif
  end

  assign accept    = in_valid && (state == IDLE);
  assign mdu_start = accept && md_sel && !md_spec;

  mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk   (clk),
    .rst   (rst),
    .start (mdu_start),
    .funct (md_funct),
    .a     (a),
    .b     (b),
    .done  (mdu_done),
    .res   (mdu_res)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nxt = mdu_start ? CALC : DONE;
      end
      CALC: begin
        busy = 1'b1;
        if (mdu_done) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r     <= '0;
      flg_q <= '0;
    end else if (accept && !mdu_start) begin
      r     <= md_sel ? md_val : alu_r;
      flg_q <= md_sel ? md_flags(md_val) : alu_f;
    end else if (state == CALC && mdu_done) begin
      r     <= mdu_res;
      flg_q <= md_flags(mdu_res);
    end
  end

  assign cf = flg_q.cf;
  assign zf = flg_q.zf;
  assign vf = flg_q.vf;
  assign sf = flg_q.sf;

endmodule

// File: tb/tb_alu_seq_mdu.sv
// Directed vector table plus hand sequences for hold, reset-abort,
// ignored in_valid during CALC and a 16-bit shift instance.
module tb_alu_seq_mdu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, md_sel, itype, out_valid, out_ready;
  logic        cf, zf, vf, sf, busy;
  logic [3:0]  alufn;
  logic [2:0]  md_funct;
  logic [4:0]  shamt;
  logic [31:0] a, b, r;

  logic        in_valid16, in_ready16, md_sel16, itype16, out_valid16, out_ready16;
  logic        cf16, zf16, vf16, sf16, busy16;
  logic [3:0]  alufn16;
  logic [2:0]  md_funct16;
  logic [3:0]  shamt16;
  logic [15:0] a16, b16, r16;

  alu_seq_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alufn(alufn), .md_sel(md_sel), .md_funct(md_funct), .itype(itype),
    .shamt(shamt), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .cf(cf), .zf(zf), .vf(vf), .sf(sf), .busy(busy)
  );

  alu_seq_mdu #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .alufn(alufn16), .md_sel(md_sel16), .md_funct(md_funct16), .itype(itype16),
    .shamt(shamt16), .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
    .r(r16), .cf(cf16), .zf(zf16), .vf(vf16), .sf(sf16), .busy(busy16)
  );

  typedef struct {
    logic [3:0]  fn;
    logic        ms;
    logic [2:0]  mf;
    logic        it;
    logic [4:0]  sh;
    logic [31:0] av, bv, er;
    logic [3:0]  ef, fm;   // expected {cf,zf,vf,sf} and which of them to check
    int          eb;       // expected busy cycles
  } vec_t;

  vec_t vq[$];
  int ntests = 0, nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkb(input logic [3:0] fn, input logic it, input logic [4:0] sh,
                               input logic [31:0] av, bv, er, input logic [3:0] ef, fm);
    vec_t t;
    t.fn = fn; t.ms = 1'b0; t.mf = 3'd0; t.it = it; t.sh = sh;
    t.av = av; t.bv = bv; t.er = er; t.ef = ef; t.fm = fm; t.eb = 0;
    return t;
  endfunction

  function automatic vec_t mkm(input logic [2:0] mf, input logic [31:0] av, bv, er, input int eb);
    vec_t t;
    t.fn = 4'd0; t.ms = 1'b1; t.mf = mf; t.it = 1'b0; t.sh = 5'd0;
    t.av = av; t.bv = bv; t.er = er; t.eb = eb;
    t.ef = {1'b0, er == 32'd0, 1'b0, er[31]};
    t.fm = 4'hF;
    return t;
  endfunction

  task automatic drive(input vec_t v);
    @(negedge clk);
    alufn = v.fn; md_sel = v.ms; md_funct = v.mf; itype = v.it; shamt = v.sh;
    a = v.av; b = v.bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Polls from the cycle after accept until out_valid, counting busy cycles.
  task automatic wait_done(output int nb, output logic ok);
    nb = 0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      if (busy) nb++;
      @(posedge clk); #1;
    end
  endtask

  task automatic release_out(input string nm);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({nm, "_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  int   nb;
  logic ok;
  vec_t v;

  initial begin
    rst = 1'b1; in_valid = 0; alufn = 0; md_sel = 0; md_funct = 0; itype = 0;
    shamt = 0; a = 0; b = 0; out_ready = 0;
    in_valid16 = 0; alufn16 = 0; md_sel16 = 0; md_funct16 = 0; itype16 = 0;
    shamt16 = 0; a16 = 0; b16 = 0; out_ready16 = 0;

    vq.push_back(mkb(ALU_SUB,  0, 0, 32'd5,        32'd5,        32'd0,        4'b1100, 4'b1111));
    vq.push_back(mkb(ALU_SLT,  0, 0, 32'hFFFFFFFF, 32'd1,        32'd1,        4'b1001, 4'b1111));
    vq.push_back(mkb(ALU_SLTU, 0, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b1001, 4'b1111));
    vq.push_back(mkb(ALU_ADD,  0, 0, 32'd3,        32'd4,        32'd7,        4'b0000, 4'b1100));
    vq.push_back(mkb(ALU_SUB,  0, 0, 32'h80000000, 32'd1,        32'h7FFFFFFF, 4'b1010, 4'b1111));
    vq.push_back(mkb(ALU_AND,  0, 0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 4'b0000, 4'b0000));
    vq.push_back(mkb(ALU_XOR,  0, 0, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 4'b0000, 4'b0000));
    vq.push_back(mkb(ALU_OR,   0, 0, 32'h12340000, 32'h00005678, 32'h12345678, 4'b0000, 4'b0000));
    vq.push_back(mkb(ALU_PASSB,0, 0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 4'b0000, 4'b0000));
    vq.push_back(mkb(ALU_SLL,  0, 0, 32'd1,        32'd36,       32'h00000010, 4'b0000, 4'b0000));
    vq.push_back(mkb(ALU_SRL,  1, 8, 32'h80000000, 32'd0,        32'h00800000, 4'b0000, 4'b0000));
    vq.push_back(mkb(ALU_SRA,  0, 0, 32'h80000000, 32'd4,        32'hF8000000, 4'b0000, 4'b0000));
    vq.push_back(mkb(4'b0010,  0, 0, 32'h12345678, 32'h1,        32'h0,        4'b0000, 4'b0000));
    vq.push_back(mkm(MD_MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 33));
    vq.push_back(mkm(MD_MULH,   32'h80000000, 32'd2,        32'hFFFFFFFF, 33));
    vq.push_back(mkm(MD_MULHU,  32'h80000000, 32'd2,        32'h00000001, 33));
    vq.push_back(mkm(MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33));
    vq.push_back(mkm(MD_MUL,    32'd0,        32'd5,        32'd0,        33));
`ifdef ALU_DIV_EN
    vq.push_back(mkm(MD_DIV,  32'd7,        32'd0,        32'hFFFFFFFF, 0));
    vq.push_back(mkm(MD_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0));
    vq.push_back(mkm(MD_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0));
    vq.push_back(mkm(MD_REM,  32'd5,        32'd0,        32'd5,        0));
    vq.push_back(mkm(MD_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33));
    vq.push_back(mkm(MD_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33));
    vq.push_back(mkm(MD_DIVU, 32'd100,      32'd7,        32'd14,       33));
    vq.push_back(mkm(MD_REMU, 32'd100,      32'd7,        32'd2,        33));
`else
    vq.push_back(mkm(MD_DIV,  32'd7,        32'd0,        32'd0,        0));
    vq.push_back(mkm(MD_DIVU, 32'd100,      32'd7,        32'd0,        0));
    vq.push_back(mkm(MD_REM,  32'hFFFFFFF9, 32'd2,        32'd0,        0));
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_r",        r, 32'd0);
    chk("rst_flags",    {28'd0, cf, zf, vf, sf}, 32'd0);
    chk("rst_out_valid",{31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy",     {31'd0, busy}, 32'd0);
    @(negedge clk); rst = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i]);
      wait_done(nb, ok);
      chk($sformatf("v%0d_done", i), {31'd0, ok}, 32'd1);
      chk($sformatf("v%0d_r", i), r, vq[i].er);
      chk($sformatf("v%0d_busy", i), nb, vq[i].eb);
      if (vq[i].fm != 4'd0)
        chk($sformatf("v%0d_flags", i), {28'd0, {cf, zf, vf, sf} & vq[i].fm},
            {28'd0, vq[i].ef & vq[i].fm});
      release_out($sformatf("v%0d", i));
    end

    // Result held while the consumer stalls.
    drive(mkb(ALU_SUB, 0, 0, 32'd5, 32'd5, 32'd0, 4'd0, 4'd0));
    wait_done(nb, ok);
    chk("hold_done", {31'd0, ok}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("hold%0d_r", k), r, 32'd0);
      chk($sformatf("hold%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
    end
    release_out("hold");

    // Reset on the tenth CALC cycle aborts the multiply.
    drive(mkm(MD_MUL, 32'd3, 32'd5, 32'd15, 33));
    nb = 0;
    for (int k = 0; k < 50 && nb < 10; k++) begin
      if (busy) nb++;
      if (nb < 10) begin @(posedge clk); #1; end
    end
    chk("abort_busy_reached", nb, 32'd10);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("abort_busy",      {31'd0, busy}, 32'd0);
    chk("abort_r",         r, 32'd0);
    @(negedge clk); rst = 1'b0;
    drive(mkb(ALU_ADD, 0, 0, 32'd3, 32'd4, 32'd7, 4'd0, 4'd0));
    wait_done(nb, ok);
    chk("post_abort_done", {31'd0, ok}, 32'd1);
    chk("post_abort_r",    r, 32'd7);
    chk("post_abort_busy", nb, 32'd0);
    release_out("post_abort");

    // in_valid with new operands during CALC must be ignored.
    drive(mkm(MD_MULHU, 32'h80000000, 32'd2, 32'd1, 33));
    repeat (5) @(posedge clk);
    @(negedge clk);
    md_sel = 1'b0; alufn = ALU_ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(nb, ok);
    chk("ign_done", {31'd0, ok}, 32'd1);
    chk("ign_r",    r, 32'd1);
    chk("ign_busy", nb + 6, 32'd33);
    release_out("ign");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("ign_idle%0d", k), {31'd0, out_valid}, 32'd0);
    end

    // 16-bit instance: immediate arithmetic shift.
    @(negedge clk);
    alufn16 = ALU_SRA; itype16 = 1'b1; shamt16 = 4'd4; a16 = 16'h8000; b16 = 16'h0003;
    in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    chk("x16_valid", {31'd0, out_valid16}, 32'd1);
    chk("x16_r",     {16'd0, r16}, 32'h0000F800);
    @(negedge clk); out_ready16 = 1'b1;
    @(posedge clk); #1; out_ready16 = 1'b0;
    chk("x16_drop",  {31'd0, out_valid16}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
